// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART receive path.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } rx_state_e;

   // Clocks per serial bit; integer divide, so the rate error is truncated.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser followed by a 3-tap majority vote. Everything
// resets to 1 so an idle-high line never looks like a start bit.
module uart_rx_sync_vote (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic line,
   output logic vote
);

   logic [1:0] sync;
   logic [2:0] taps;

   // Synchronise the pin and keep the three most recent synchronised samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: reset to the idle level (1), not 0, or every reset release fakes a start bit.
         sync <= 2'b11;
         taps <= 3'b111;
      end else begin
         // NOTE: non-blocking so each stage captures the previous stage's old value.
         sync <= {sync[0], din};
         taps <= {taps[1:0], sync[1]};
      end
   end

   assign line = sync[1];
   assign vote = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable width/parity/stop bits, majority
// sampling, error flags and a valid/ready holding register.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLK_RATE  = 100000000,
   parameter int BAUD_RATE = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 uart_data_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int BIT_W        = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);
   localparam logic             PAR_ON     = (PARITY != PARITY_NONE);
   localparam logic             PAR_TARGET = (PARITY == PARITY_ODD);

   rx_state_e            state, state_nxt;
   logic [CNT_W-1:0]     clk_cnt;
   logic [BIT_W-1:0]     bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_err_q;
   logic                 frm_err_q;
   logic                 line;
   logic                 vote;
   logic                 start_pt;
   logic                 bit_pt;
   logic                 stop_last;
   logic                 frame_done;

   uart_rx_sync_vote u_sync_vote (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (uart_data_in),
      .line  (line),
      .vote  (vote)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; a low last stop sample parks in WAIT_HIGH until the line recovers.
   always_comb begin
      // NOTE: default first so no path through the case leaves state_nxt unassigned (latch).
      state_nxt = state;
      case (state)
         S_IDLE:      if (!line) state_nxt = S_START;
         S_START:     if (start_pt) state_nxt = vote ? S_IDLE : S_DATA;
         S_DATA:      if (bit_pt && bit_idx == BIT_LAST) state_nxt = PAR_ON ? S_PARITY : S_STOP;
         S_PARITY:    if (bit_pt) state_nxt = S_STOP;
         S_STOP:      if (frame_done) state_nxt = vote ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (line) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Sample strobes and status derived from the current state.
   always_comb begin
      busy       = (state != S_IDLE);
      start_pt   = (state == S_START) && (clk_cnt == CNT_HALF);
      bit_pt     = ((state == S_DATA) || (state == S_PARITY) || (state == S_STOP)) &&
                   (clk_cnt == CNT_LAST);
      stop_last  = (STOP_BITS == 1) || stop_idx;
      frame_done = (state == S_STOP) && bit_pt && stop_last;
   end

   // Bit timing counter, payload shift register and per-frame error accumulators.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt   <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shift_reg <= '0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
      end else begin
         case (state)
            S_START: begin
               if (start_pt) begin
                  clk_cnt   <= '0;
                  bit_idx   <= '0;
                  stop_idx  <= 1'b0;
                  par_err_q <= 1'b0;
                  frm_err_q <= 1'b0;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_DATA, S_PARITY, S_STOP: begin
               if (bit_pt) begin
                  clk_cnt <= '0;
                  if (state == S_DATA) begin
                     // LSB arrives first, so shifting right leaves bit 0 at the bottom.
                     shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                     bit_idx   <= bit_idx + 1'b1;
                  end else if (state == S_PARITY) begin
                     par_err_q <= PAR_ON && ((^shift_reg ^ vote) != PAR_TARGET);
                  end else begin
                     if (!vote) frm_err_q <= 1'b1;
                     stop_idx <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: clk_cnt <= '0;
         endcase
      end
   end

   // Holding register: load a completed frame if there is room, otherwise drop it and flag overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (frame_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shift_reg;
               parity_err <= par_err_q;
               frame_err  <= frm_err_q | ~vote;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: five receiver configurations at 16 clocks
// per bit, driven from one sequence and checked against a frame scoreboard.
module tb_uart_rx_frame;

   localparam int CPB = 16;

   typedef struct {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [4:0] line;
   logic [4:0] ready;

   wire  [7:0] d0, d1, d2, d3;
   wire  [6:0] d4;
   wire  [8:0] data_w [5];
   wire  [4:0] valid_w, perr_w, ferr_w, ovr_w, busy_w;

   int   n_tests  = 0;
   int   n_fail   = 0;
   int   ovr_seen = 0;
   exp_t sb[$];

   assign data_w[0] = {1'b0, d0};
   assign data_w[1] = {1'b0, d1};
   assign data_w[2] = {1'b0, d2};
   assign data_w[3] = {1'b0, d3};
   assign data_w[4] = {2'b00, d4};

   // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2, 4: 7N1
   uart_rx_frame #(.CLK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .uart_data_in(line[0]), .rx_data(d0), .rx_valid(valid_w[0]),
      .rx_ready(ready[0]), .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .overrun(ovr_w[0]), .busy(busy_w[0]));
   uart_rx_frame #(.CLK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst_n(rst_n), .uart_data_in(line[1]), .rx_data(d1), .rx_valid(valid_w[1]),
      .rx_ready(ready[1]), .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .overrun(ovr_w[1]), .busy(busy_w[1]));
   uart_rx_frame #(.CLK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .uart_data_in(line[2]), .rx_data(d2), .rx_valid(valid_w[2]),
      .rx_ready(ready[2]), .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .overrun(ovr_w[2]), .busy(busy_w[2]));
   uart_rx_frame #(.CLK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
      .clk(clk), .rst_n(rst_n), .uart_data_in(line[3]), .rx_data(d3), .rx_valid(valid_w[3]),
      .rx_ready(ready[3]), .parity_err(perr_w[3]), .frame_err(ferr_w[3]), .overrun(ovr_w[3]), .busy(busy_w[3]));
   uart_rx_frame #(.CLK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7n1 (
      .clk(clk), .rst_n(rst_n), .uart_data_in(line[4]), .rx_data(d4), .rx_valid(valid_w[4]),
      .rx_ready(ready[4]), .parity_err(perr_w[4]), .frame_err(ferr_w[4]), .overrun(ovr_w[4]), .busy(busy_w[4]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count overrun pulses on the 8N1 receiver, sampled mid-cycle.
   always @(negedge clk) if (ovr_w[0]) ovr_seen++;

   // Hard stop in case a sequence step wedges.
   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic int nbits(input int idx);
      return (idx == 4) ? 7 : 8;
   endfunction

   function automatic int pmode(input int idx);
      return (idx == 1) ? 2 : (idx == 2) ? 1 : 0;
   endfunction

   function automatic int nstop(input int idx);
      return (idx == 3) ? 2 : 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One bit period; an optional 1-clock inverted glitch lands near the bit centre.
   task automatic drive_bit(input int idx, input logic b, input bit glitch);
      for (int c = 0; c < CPB; c++) begin
         line[idx] = (glitch && c == 8) ? ~b : b;
         @(negedge clk);
      end
   endtask

   // Drive a full frame; optionally push the expected result to the scoreboard.
   task automatic send_frame(input int idx, input logic [8:0] data, input logic pbit,
                             input logic [1:0] stops, input int glitch_bit, input bit push);
      exp_t e;
      logic x;
      x = pbit;
      for (int i = 0; i < nbits(idx); i++) x = x ^ data[i];
      e.data = data;
      e.perr = (pmode(idx) != 0) && (x != (pmode(idx) == 1));
      e.ferr = 1'b0;
      for (int s = 0; s < nstop(idx); s++) if (!stops[s]) e.ferr = 1'b1;
      if (push) sb.push_back(e);
      drive_bit(idx, 1'b0, 1'b0);
      for (int i = 0; i < nbits(idx); i++) drive_bit(idx, data[i], i == glitch_bit);
      if (pmode(idx) != 0) drive_bit(idx, pbit, 1'b0);
      for (int s = 0; s < nstop(idx); s++) drive_bit(idx, stops[s], 1'b0);
   endtask

   // Wait (bounded) for a held frame, compare with the scoreboard, then accept it.
   task automatic expect_frame(input int idx, input string tag);
      exp_t e;
      int   t;
      t = 0;
      while (!valid_w[idx] && t < 400) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_valid"}, valid_w[idx], 1);
      check({tag, "_sb"}, (sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_data"}, data_w[idx], e.data);
         check({tag, "_perr"}, perr_w[idx], e.perr);
         check({tag, "_ferr"}, ferr_w[idx], e.ferr);
      end
      ready[idx] = 1'b1;
      @(negedge clk);
      ready[idx] = 1'b0;
      check({tag, "_drop"}, valid_w[idx], 0);
   endtask

   initial begin
      int snap;
      rst_n = 1'b0;
      line  = '1;
      ready = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", valid_w, 0);
      check("rst_busy", busy_w, 0);
      check("rst_data0", data_w[0], 0);
      check("rst_perr", perr_w, 0);
      check("rst_ferr", ferr_w, 0);
      check("rst_ovr", ovr_w, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_busy", busy_w, 0);

      // 8N1 basic frame
      send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, 1'b1);
      expect_frame(0, "8n1_a5");
      check("8n1_busy", busy_w[0], 0);

      // Parity: even with wrong bit, even with right bit, odd with right bit
      send_frame(1, 9'h003, 1'b1, 2'b11, -1, 1'b1);
      expect_frame(1, "8e1_bad");
      send_frame(1, 9'h003, 1'b0, 2'b11, -1, 1'b1);
      expect_frame(1, "8e1_good");
      send_frame(2, 9'h003, 1'b1, 2'b11, -1, 1'b1);
      expect_frame(2, "8o1_good");

      // 8N2 with low second stop bit and the line held low afterwards
      send_frame(3, 9'h03C, 1'b0, 2'b01, -1, 1'b1);
      repeat (40) @(negedge clk);
      expect_frame(3, "8n2_ferr");
      repeat (10) @(negedge clk);
      check("8n2_no_new", valid_w[3], 0);
      check("8n2_wait_busy", busy_w[3], 1);
      line[3] = 1'b1;
      repeat (5) @(negedge clk);
      check("8n2_idle", busy_w[3], 0);

      // Short low pulse on the idle line is rejected
      line[0] = 1'b0;
      repeat (6) @(negedge clk);
      line[0] = 1'b1;
      check("noise_busy_mid", busy_w[0], 1);
      repeat (30) @(negedge clk);
      check("noise_valid", valid_w[0], 0);
      check("noise_busy", busy_w[0], 0);

      // 1-clock glitch inside data bit 3
      send_frame(0, 9'h05A, 1'b0, 2'b11, 3, 1'b1);
      expect_frame(0, "glitch_5a");

      // Overrun: second frame dropped while the first is held
      snap = ovr_seen;
      send_frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b1);
      send_frame(0, 9'h022, 1'b0, 2'b11, -1, 1'b0);
      repeat (4) @(negedge clk);
      check("ovr_count", ovr_seen - snap, 1);
      expect_frame(0, "ovr_held_11");
      send_frame(0, 9'h033, 1'b0, 2'b11, -1, 1'b1);
      expect_frame(0, "after_ovr_33");

      // Reset mid-frame with a frame already held
      send_frame(0, 9'h05A, 1'b0, 2'b11, -1, 1'b0);
      check("pre_rst_valid", valid_w[0], 1);
      drive_bit(0, 1'b0, 1'b0);
      drive_bit(0, 1'b1, 1'b0);
      drive_bit(0, 1'b1, 1'b0);
      drive_bit(0, 1'b0, 1'b0);
      check("pre_rst_busy", busy_w[0], 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", valid_w, 0);
      check("mid_rst_busy", busy_w, 0);
      check("mid_rst_data0", data_w[0], 0);
      check("mid_rst_flags", {perr_w, ferr_w, ovr_w}, 0);
      @(negedge clk);
      line[0] = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_busy", busy_w, 0);

      // 7-bit receiver
      send_frame(4, 9'h07E, 1'b0, 2'b11, -1, 1'b1);
      expect_frame(4, "7n1_7e");
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
